// File: rtl/ps2_keyboard_rx_if.sv
// Key-event bus from the PS/2 receiver to downstream key-action logic.
// scan_code_ready is a one-cycle valid with no back-pressure; scan_code/is_break/is_extended are levels that are
// valid from that cycle until the next event, and frame_error is a separate one-cycle strobe never coincident with ready.
interface ps2_keyboard_rx_if;
    logic [7:0] scan_code;
    logic       scan_code_ready;
    logic       is_break;
    logic       is_extended;
    logic       frame_error;

    modport master (
        output scan_code,
        output scan_code_ready,
        output is_break,
        output is_extended,
        output frame_error
    );

    modport slave (
        input scan_code,
        input scan_code_ready,
        input is_break,
        input is_extended,
        input frame_error
    );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: synchronise and debounce the pins, deframe 11-bit frames,
// and fold E0/F0 prefixes into is_extended/is_break on a single strobe per key event.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 250_000,
    parameter int REPORT_BREAK   = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    ps2_keyboard_rx_if.master        kb,
    output logic [1:0]               dbg_state
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic            filt_q, filt_d;
    logic [7:0]      fcnt_q, fcnt_d;
    logic            fall;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bcnt_q, bcnt_d;
    logic            par_q, par_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            timeout;
    logic            frame_ok;
    logic            brk_pend_q, brk_pend_d, ext_pend_q, ext_pend_d;
    logic [7:0]      code_q, code_d;
    logic            brk_q, brk_d, ext_q, ext_d, rdy_q, rdy_d, err_q, err_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
        end
    end

    // Filtered clock follows the synced pin only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == 8'(FILTER_LEN - 1)) filt_d = clk_s2_q;
            else                              fcnt_d = fcnt_q + 8'd1;
        end
    end

    assign fall    = filt_q & ~filt_d;
    assign timeout = (state_q != IDLE) && !fall && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign tcnt_d  = (state_q == IDLE || fall || timeout) ? '0 : tcnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = IDLE;
        end else if (fall) begin
            case (state_q)
                IDLE:    if (!dat_s2_q) state_d = DATA;
                DATA:    if (bcnt_q == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                default: state_d = IDLE;
            endcase
        end
    end

    // Odd parity over data+parity, plus stop bit high, qualifies the byte.
    assign frame_ok = dat_s2_q & (^{shift_q, par_q});

    always_comb begin
        shift_d    = shift_q;
        bcnt_d     = bcnt_q;
        par_d      = par_q;
        brk_pend_d = brk_pend_q;
        ext_pend_d = ext_pend_q;
        code_d     = code_q;
        brk_d      = brk_q;
        ext_d      = ext_q;
        rdy_d      = 1'b0;
        err_d      = 1'b0;
        if (timeout) begin
            err_d      = 1'b1;
            brk_pend_d = 1'b0;
            ext_pend_d = 1'b0;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    if (dat_s2_q) begin
                        err_d      = 1'b1;
                        brk_pend_d = 1'b0;
                        ext_pend_d = 1'b0;
                    end else begin
                        bcnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    bcnt_d  = bcnt_q + 3'd1;
                end
                PARITY: par_d = dat_s2_q;
                default: begin
                    if (!frame_ok) begin
                        err_d      = 1'b1;
                        brk_pend_d = 1'b0;
                        ext_pend_d = 1'b0;
                    end else if (shift_q == 8'hF0) begin
                        brk_pend_d = 1'b1;
                    end else if (shift_q == 8'hE0) begin
                        ext_pend_d = 1'b1;
                    end else begin
                        brk_pend_d = 1'b0;
                        ext_pend_d = 1'b0;
                        // Silent break events leave the visible levels untouched.
                        if (!brk_pend_q || REPORT_BREAK != 0) begin
                            code_d = shift_q;
                            brk_d  = brk_pend_q;
                            ext_d  = ext_pend_q;
                            rdy_d  = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q    <= '0;
            bcnt_q     <= '0;
            par_q      <= 1'b0;
            tcnt_q     <= '0;
            brk_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
            code_q     <= '0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            bcnt_q     <= bcnt_d;
            par_q      <= par_d;
            tcnt_q     <= tcnt_d;
            brk_pend_q <= brk_pend_d;
            ext_pend_q <= ext_pend_d;
            code_q     <= code_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
        end
    end

    assign kb.scan_code       = code_q;
    assign kb.scan_code_ready = rdy_q;
    assign kb.is_break        = brk_q;
    assign kb.is_extended     = ext_q;
    assign kb.frame_error     = err_q;
    assign dbg_state          = state_q;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: two instances (silent and reported breaks) share one PS/2 pin pair
// and are compared against a key-event model kept at the byte/event level.
module tb_ps2_keyboard_rx;
    localparam int FL   = 8;
    localparam int TO   = 2000;
    localparam int HALF = 40;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic [1:0] dbg0, dbg1;

    always #5 clk = ~clk;

    ps2_keyboard_rx_if kb0 ();
    ps2_keyboard_rx_if kb1 ();

    ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .REPORT_BREAK(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .kb(kb0), .dbg_state(dbg0)
    );
    ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .REPORT_BREAK(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .kb(kb1), .dbg_state(dbg1)
    );

    // Observed events, one entry per ready cycle: {is_break, is_extended, scan_code}
    logic [9:0] got0_q[$], got1_q[$];
    int err0 = 0, err1 = 0, both_cnt = 0;

    always @(negedge clk) begin
        if (kb0.scan_code_ready) got0_q.push_back({kb0.is_break, kb0.is_extended, kb0.scan_code});
        if (kb1.scan_code_ready) got1_q.push_back({kb1.is_break, kb1.is_extended, kb1.scan_code});
        if (kb0.frame_error) err0++;
        if (kb1.frame_error) err1++;
        if ((kb0.scan_code_ready && kb0.frame_error) || (kb1.scan_code_ready && kb1.frame_error)) both_cnt++;
    end

    // Reference model: expected events and visible levels per instance (index 1 reports breaks)
    logic [9:0] exp0_q[$], exp1_q[$];
    logic [7:0] m_code [2];
    logic       m_brk  [2];
    logic       m_ext  [2];
    logic       m_bp, m_ep;
    int         exp_err = 0;
    int         idx0 = 0, idx1 = 0;
    int         n_asrt = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_code[d] = 8'h00;
            m_brk[d]  = 1'b0;
            m_ext[d]  = 1'b0;
        end
        m_bp = 1'b0;
        m_ep = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic bad);
        if (bad) begin
            exp_err++;
            m_bp = 1'b0;
            m_ep = 1'b0;
        end else if (b == 8'hF0) begin
            m_bp = 1'b1;
        end else if (b == 8'hE0) begin
            m_ep = 1'b1;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!m_bp || d == 1) begin
                    m_code[d] = b;
                    m_brk[d]  = m_bp;
                    m_ext[d]  = m_ep;
                    if (d == 0) exp0_q.push_back({m_bp, m_ep, b});
                    else        exp1_q.push_back({m_bp, m_ep, b});
                end
            end
            m_bp = 1'b0;
            m_ep = 1'b0;
        end
    endtask

    task automatic model_abort();
        exp_err++;
        m_bp = 1'b0;
        m_ep = 1'b0;
    endtask

    // Drive nbits of a frame; bad flips the parity bit, glitch inserts 3-cycle pulses in both phases.
    task automatic send_frame(input logic [7:0] b, input logic bad, input int nbits, input logic glitch);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = fr[i];
            if (glitch) begin
                repeat (20) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (3) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (HALF - 23) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b0;
            if (glitch) begin
                repeat (20) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (3) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (HALF - 23) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        repeat (5) @(negedge clk);
        chk({tag, " ev_cnt0"}, 32'(got0_q.size()), 32'(exp0_q.size()));
        chk({tag, " ev_cnt1"}, 32'(got1_q.size()), 32'(exp1_q.size()));
        for (int i = idx0; i < got0_q.size() && i < exp0_q.size(); i++)
            chk({tag, " ev0"}, 32'(got0_q[i]), 32'(exp0_q[i]));
        for (int i = idx1; i < got1_q.size() && i < exp1_q.size(); i++)
            chk({tag, " ev1"}, 32'(got1_q[i]), 32'(exp1_q[i]));
        idx0 = exp0_q.size();
        idx1 = exp1_q.size();
        chk({tag, " err0"}, 32'(err0), 32'(exp_err));
        chk({tag, " err1"}, 32'(err1), 32'(exp_err));
        chk({tag, " ready_with_error"}, 32'(both_cnt), 32'd0);
        chk({tag, " code0"}, 32'(kb0.scan_code), 32'(m_code[0]));
        chk({tag, " code1"}, 32'(kb1.scan_code), 32'(m_code[1]));
        chk({tag, " flags0"}, 32'({kb0.is_break, kb0.is_extended}), 32'({m_brk[0], m_ext[0]}));
        chk({tag, " flags1"}, 32'({kb1.is_break, kb1.is_extended}), 32'({m_brk[1], m_ext[1]}));
        chk({tag, " idle0"}, 32'(dbg0), 32'd0);
        chk({tag, " idle1"}, 32'(dbg1), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " outs0"}, 32'({kb0.scan_code, kb0.scan_code_ready, kb0.is_break, kb0.is_extended, kb0.frame_error}), 32'd0);
        chk({tag, " outs1"}, 32'({kb1.scan_code, kb1.scan_code_ready, kb1.is_break, kb1.is_extended, kb1.frame_error}), 32'd0);
        chk({tag, " state"}, 32'({dbg0, dbg1}), 32'd0);
    endtask

    task automatic key(input logic [7:0] b, input logic bad, input logic glitch, input string tag);
        send_frame(b, bad, 11, glitch);
        model_byte(b, bad);
        check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        key(8'h1C, 1'b0, 1'b0, "make_1c");
        key(8'hF0, 1'b0, 1'b0, "prefix_f0");
        key(8'h32, 1'b0, 1'b0, "break_32");
        key(8'hE0, 1'b0, 1'b0, "prefix_e0");
        key(8'h75, 1'b0, 1'b0, "ext_75");
        key(8'hE0, 1'b0, 1'b0, "prefix_e0b");
        key(8'hF0, 1'b0, 1'b0, "prefix_f0b");
        key(8'h75, 1'b0, 1'b0, "ext_break_75");
        key(8'h23, 1'b1, 1'b0, "parity_err_23");

        // Prefixes pending, then a truncated frame that must time out and drop them
        key(8'hF0, 1'b0, 1'b0, "pre_to_f0");
        key(8'hE0, 1'b0, 1'b0, "pre_to_e0");
        send_frame(8'h5A, 1'b0, 4, 1'b0);
        repeat (TO + 200) @(negedge clk);
        model_abort();
        check_all("timeout");
        key(8'h1C, 1'b0, 1'b0, "after_timeout_1c");

        key(8'h1C, 1'b0, 1'b1, "glitch_1c");

        // Reset in the middle of a frame
        send_frame(8'h4B, 1'b0, 5, 1'b0);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        model_reset();
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check_all("post_reset");
        key(8'h1C, 1'b0, 1'b0, "after_reset_1c");

        for (int n = 0; n < 20; n++) begin
            logic [7:0] b;
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 2)       b = 8'hF0;
            else if (r == 2) b = 8'hE0;
            else             b = 8'($urandom_range(0, 255));
            key(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
